// File: rtl/usrt_tx_pkg.sv
// Shared definitions for the USRT transmitter and receiver.
// Holds the default status codes, the idle line level, the frame geometry
// (3 bytes of 10 bit-slots: start, 8 data MSB first, stop), the transmit
// FSM state type and the byte-selection helper.
package usrt_tx_pkg;

    localparam logic [7:0] ERR_CODE_DEF = 8'hEE;
    localparam logic [7:0] OK_CODE_DEF  = 8'h00;
    localparam logic       IDLE_LEVEL   = 1'b1;
    localparam logic       START_LEVEL  = 1'b0;
    localparam logic       STOP_LEVEL   = 1'b1;

    localparam int unsigned FRAME_BYTES = 3;
    localparam logic [1:0]  LAST_BYTE   = 2'(FRAME_BYTES - 1);
    localparam logic [2:0]  LAST_BIT    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Byte order on the line: status, result high byte, result low byte.
    function automatic logic [7:0] select_byte(
        input logic [1:0]  idx,
        input logic [15:0] data,
        input logic [7:0]  status
    );
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = status;
            2'd1:    sel = data[15:8];
            default: sel = data[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/usrt_edge.sv
// Two-flop synchroniser plus falling-edge detector for the host USRT clock.
// The host clock is treated as data in the clk16M domain.
//   clk16M : system clock, rising edge
//   rst    : synchronous active-high reset (flops preset to 1 = idle clock)
//   in     : asynchronous input to synchronise
//   fall   : one-cycle pulse when the synchronised input goes 1 -> 0
module usrt_edge (
    input  logic clk16M,
    input  logic rst,
    input  logic in,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk16M) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], in};
            prev_q <= sync_q[1];
        end
    end

    assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/usrt_tx.sv
// USRT response transmitter. On an accepted strt it latches the result word
// and error flag, then shifts out a 3-byte frame (status, data high, data low)
// clocked by falling edges of the host-driven usrt_clk.
//   clk16M   : system clock
//   rst      : synchronous active-high reset, aborts any frame
//   usrt_clk : host USRT clock, sampled as data
//   strt     : one-cycle start pulse, honoured only when idle
//   data_in  : 16-bit result word
//   err      : error flag, selects ERR_CODE / OK_CODE status byte
//   miso     : registered TX line, idles high
//   busy     : high while a frame is in progress
//   rdy      : one-cycle pulse at frame completion
module usrt_tx
    import usrt_tx_pkg::*;
#(
    parameter logic [7:0] ERR_CODE = ERR_CODE_DEF,
    parameter logic [7:0] OK_CODE  = OK_CODE_DEF
) (
    input  logic        clk16M,
    input  logic        rst,
    input  logic        usrt_clk,
    input  logic        strt,
    input  logic [15:0] data_in,
    input  logic        err,
    output logic        miso,
    output logic        busy,
    output logic        rdy
);

    logic       fall_tick;

    tx_state_t  state_q, state_d;
    logic [1:0] byte_q,  byte_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic [15:0] data_q, data_d;
    logic       err_q,   err_d;
    logic       pend_q,  pend_d;
    logic       miso_q,  miso_d;
    logic       busy_q,  busy_d;
    logic       rdy_q,   rdy_d;
    logic [7:0] cur_byte;

    usrt_edge u_edge (
        .clk16M (clk16M),
        .rst    (rst),
        .in     (usrt_clk),
        .fall   (fall_tick)
    );

    // State names the slot currently on the line. START is entered with the
    // start bit still pending (line high); the first fall_tick drives it,
    // and the next one ends it and drives data bit 7 from the freshly
    // selected byte while loading the remaining bits into the shifter.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        err_d    = err_q;
        pend_d   = pend_q;
        miso_d   = miso_q;
        rdy_d    = 1'b0;
        cur_byte = select_byte(byte_q, data_q, err_q ? ERR_CODE : OK_CODE);

        case (state_q)
            S_IDLE: begin
                miso_d = IDLE_LEVEL;
                if (strt) begin
                    data_d  = data_in;
                    err_d   = err;
                    byte_d  = '0;
                    bit_d   = '0;
                    pend_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (fall_tick) begin
                    if (pend_q) begin
                        miso_d = START_LEVEL;
                        pend_d = 1'b0;
                    end else begin
                        miso_d  = cur_byte[7];
                        shreg_d = {cur_byte[6:0], 1'b0};
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fall_tick) begin
                    if (bit_q == LAST_BIT) begin
                        miso_d  = STOP_LEVEL;
                        state_d = S_STOP;
                    end else begin
                        miso_d  = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (fall_tick) begin
                    if (byte_q == LAST_BYTE) begin
                        miso_d  = IDLE_LEVEL;
                        byte_d  = '0;
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Next start bit follows the stop bit with no gap.
                        miso_d  = START_LEVEL;
                        byte_d  = byte_q + 2'd1;
                        state_d = S_START;
                    end
                end
            end
            default: begin
                miso_d  = IDLE_LEVEL;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk16M) begin
        if (rst) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            miso_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign miso = miso_q;
    assign busy = busy_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_usrt_tx.sv
// Directed self-checking bench for usrt_tx: reset, idle clocking, normal
// and error frames, input changes and a second strt mid-frame, strt
// coincident with a falling edge, and a mid-frame reset abort.
module tb_usrt_tx;

    logic        clk16M;
    logic        rst;
    logic        usrt_clk;
    logic        strt;
    logic [15:0] data_in;
    logic        err;
    logic        miso;
    logic        busy;
    logic        rdy;

    int errors = 0;
    int checks = 0;
    int rdy_cycles = 0;

    usrt_tx #(
        .ERR_CODE (8'hEE),
        .OK_CODE  (8'h00)
    ) dut (
        .clk16M   (clk16M),
        .rst      (rst),
        .usrt_clk (usrt_clk),
        .strt     (strt),
        .data_in  (data_in),
        .err      (err),
        .miso     (miso),
        .busy     (busy),
        .rdy      (rdy)
    );

    initial clk16M = 1'b0;
    always #5 clk16M = ~clk16M;

    always @(posedge clk16M) begin
        if (rdy === 1'b1) rdy_cycles <= rdy_cycles + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] mk(input logic [7:0] s, input logic [15:0] d);
        return {1'b0, s, 1'b1, 1'b0, d[15:8], 1'b1, 1'b0, d[7:0], 1'b1};
    endfunction

    task automatic usrt_fall();
        usrt_clk = 1'b0;
        repeat (8) @(negedge clk16M);
    endtask

    task automatic usrt_rise();
        usrt_clk = 1'b1;
        repeat (8) @(negedge clk16M);
    endtask

    // mode: 0 plain, 1 clear inputs at slot 'at', 2 second strt at slot 'at',
    //       3 reset abort after slot 'at', 4 strt coincident with a fall tick
    task automatic run_frame(input string name, input logic [15:0] d, input logic e,
                             input logic [29:0] exp, input int mode, input int at);
        int   rdy0;
        logic busy_ok;
        logic found;
        rdy0    = rdy_cycles;
        busy_ok = 1'b1;
        found   = 1'b0;

        if (mode == 4) begin
            // fall reaches the FSM two clocks after usrt_clk drops
            usrt_clk = 1'b0;
            @(negedge clk16M);
            @(negedge clk16M);
            data_in = d; err = e; strt = 1'b1;
            @(negedge clk16M);
            strt = 1'b0;
            chk1({name, " busy_after_strt"}, busy, 1'b1);
            repeat (5) @(negedge clk16M);
            chk1({name, " coincident_edge_hold"}, miso, 1'b1);
            usrt_rise();
        end else begin
            data_in = d; err = e; strt = 1'b1;
            @(negedge clk16M);
            strt = 1'b0;
            chk1({name, " busy_after_strt"}, busy, 1'b1);
            chk1({name, " miso_before_first_fall"}, miso, 1'b1);
        end

        for (int slot = 0; slot < 30; slot++) begin
            usrt_fall();
            chk1($sformatf("%s slot%0d", name, slot), miso, exp[29 - slot]);
            busy_ok &= busy;
            if (mode == 1 && slot == at) begin
                data_in = 16'h0000; err = 1'b0;
            end
            if (mode == 2 && slot == at) begin
                data_in = 16'hABCD; err = 1'b1; strt = 1'b1;
                @(negedge clk16M);
                strt = 1'b0;
            end
            if (mode == 3 && slot == at) begin
                rst = 1'b1;
                @(negedge clk16M);
                rst = 1'b0;
                chk1({name, " abort_miso"}, miso, 1'b1);
                chk1({name, " abort_busy"}, busy, 1'b0);
                chk1({name, " abort_rdy"}, rdy, 1'b0);
                usrt_rise();
                for (int k = 0; k < 6; k++) begin
                    usrt_fall();
                    chk1($sformatf("%s post_abort_idle%0d", name, k), miso, 1'b1);
                    usrt_rise();
                end
                chk1({name, " post_abort_busy"}, busy, 1'b0);
                chkn({name, " abort_no_rdy"}, rdy_cycles, rdy0);
                return;
            end
            usrt_rise();
        end

        chk1({name, " busy_through_frame"}, busy_ok, 1'b1);
        chkn({name, " rdy_not_early"}, rdy_cycles, rdy0);

        usrt_clk = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk16M);
            if (rdy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk1({name, " rdy_seen"}, found, 1'b1);
        chk1({name, " busy_falls_with_rdy"}, busy, 1'b0);
        chk1({name, " miso_idle_at_end"}, miso, 1'b1);
        @(negedge clk16M);
        chk1({name, " rdy_one_cycle"}, rdy, 1'b0);
        chkn({name, " rdy_count"}, rdy_cycles, rdy0 + 1);
        usrt_rise();
    endtask

    initial begin
        rst      = 1'b1;
        usrt_clk = 1'b1;
        strt     = 1'b0;
        data_in  = 16'h0000;
        err      = 1'b0;
        repeat (3) @(negedge clk16M);
        chk1("reset miso", miso, 1'b1);
        chk1("reset busy", busy, 1'b0);
        chk1("reset rdy", rdy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk16M);

        // usrt_clk running with no strt
        for (int k = 0; k < 6; k++) begin
            usrt_fall();
            chk1($sformatf("idle_toggle miso%0d", k), miso, 1'b1);
            chk1($sformatf("idle_toggle busy%0d", k), busy, 1'b0);
            usrt_rise();
        end
        chkn("idle_toggle no_rdy", rdy_cycles, 0);

        // 0,00000000,1, 0,00010010,1, 0,00110100,1
        run_frame("ok_1234", 16'h1234, 1'b0,
                  30'b0_00000000_1_0_00010010_1_0_00110100_1, 0, 0);
        // EE, FF, FF with inputs cleared during the status byte
        run_frame("err_ffff", 16'hFFFF, 1'b1,
                  30'b0_11101110_1_0_11111111_1_0_11111111_1, 1, 5);
        run_frame("second_strt", 16'h5AC3, 1'b0, mk(8'h00, 16'h5AC3), 2, 14);
        run_frame("coincident", 16'h8001, 1'b1, mk(8'hEE, 16'h8001), 4, 0);
        // slot 24 is bit 3 of the third byte
        run_frame("abort", 16'h1234, 1'b0, mk(8'h00, 16'h1234), 3, 24);
        run_frame("after_abort", 16'hC35A, 1'b0, mk(8'h00, 16'hC35A), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usrt_tx.md
USRT_TX -- requirements
Module: usrt_tx

Interface
REQ-001 SHALL have parameter ERR_CODE, default 8'hEE, status byte sent when the latched error flag is 1.
REQ-002 SHALL have parameter OK_CODE, default 8'h00, status byte sent when the latched error flag is 0.
REQ-003 SHALL have port clk16M  input  1  system clock; only clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port usrt_clk  input  1  host-driven USRT clock, sampled as data in the clk16M domain (not a clock).
REQ-006 SHALL have port strt  input  1  one-cycle pulse: capture result and begin response.
REQ-007 SHALL have port data_in  input  16  result word (BCD or binary, transmitted unmodified).
REQ-008 SHALL have port err  input  1  error flag of the current operation.
REQ-009 SHALL have port miso  output  1  USRT TX line; idle level 1.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted strt until the cycle rdy pulses.
REQ-011 SHALL have port rdy  output  1  one-cycle pulse when the response frame is complete.

Function
REQ-012 SHALL synchronise usrt_clk through 2 flops, then detect a falling edge (previous synced 1, current synced 0) as a one-cycle fall_tick.
REQ-013 SHALL accept strt only in IDLE; strt while busy=1 SHALL be ignored with no change to the latched data.
REQ-014 On accepted strt, SHALL latch data_in and err into internal registers in that cycle; later input changes SHALL NOT affect the frame.
REQ-015 Frame SHALL be 3 bytes in order: status (ERR_CODE/OK_CODE), data_in[15:8], data_in[7:0].
REQ-016 Each byte SHALL be 10 bit-slots: start bit 0, 8 data bits MSB first, stop bit 1; no gap between bytes.
REQ-017 States: IDLE, START, DATA, STOP; byte counter 0..2; bit counter 0..7.
REQ-018 IDLE->START on accepted strt; miso stays 1 until the next fall_tick, which drives the start bit.
REQ-019 START->DATA, DATA (bit counter 7)->STOP, STOP->START (byte counter<2, counter increments), STOP->IDLE (byte counter=2); each transition on fall_tick only.
REQ-020 miso SHALL change only in the cycle after a fall_tick (registered output); the host samples on the rising edge of usrt_clk.
REQ-021 strt and fall_tick in the same cycle: SHALL latch only; the start bit SHALL be driven on the next fall_tick.
REQ-022 The fall_tick that ends the final stop bit SHALL return the FSM to IDLE with miso=1, and rdy SHALL pulse for exactly one cycle in the following cycle with busy falling together.
REQ-023 fall_tick in IDLE SHALL have no effect.
REQ-024 Total response SHALL be 30 bit-slots = 31 fall_ticks after strt (1 to the start bit, 29 between slot changes, 1 to end the stop bit).

Reset
REQ-025 While rst=1: state IDLE, counters 0, miso=1, busy=0, rdy=0, latched registers 0, synchroniser flops 1.
REQ-026 rst asserted mid-frame SHALL abort immediately; no rdy pulse; the line idles at 1 until a new strt.

Structure
REQ-027 ERR_CODE/OK_CODE defaults, idle level and frame length (3 bytes, 10 slots) SHALL live in a shared include file usrt_defs.vh, also used by usrt_rec.
REQ-028 The synchroniser and falling-edge detector SHALL be a sub-module usrt_edge (ports clk16M, rst, in, fall) reusable by the receiver.
REQ-029 Byte selection SHALL be a 3-way mux on the byte counter; shifting SHALL use a single 8-bit shift register loaded in START.

Verification
REQ-030 strt with data_in=16'h1234, err=0 -> miso slots 0,00000000,1, 0,00010010,1, 0,00110100,1; rdy pulses once; busy high throughout.
REQ-031 strt with data_in=16'hFFFF, err=1 -> first byte 8'hEE, then FF, FF; data_in changed to 0 mid-frame does not alter the output.
REQ-032 Second strt during DATA of byte 1 -> ignored; exactly one 30-slot frame; one rdy.
REQ-033 strt coincident with fall_tick -> miso stays 1 for that edge; start bit appears on the next falling edge; total of 31 fall_ticks until rdy.
REQ-034 rst pulsed after byte 2 bit 3 -> miso=1, busy=0, no rdy; a fresh strt afterwards yields a full correct frame.
REQ-035 usrt_clk toggling while idle with no strt -> miso constant 1, rdy never pulses.
